// File: rtl/controle_magnetron.sv
// Microwave magnetron controller: synchronizes the front-panel buttons and interlocks,
// then drives a one-cycle set pulse, a reset hold level and the on/off state.
module controle_magnetron (
  input  logic clk,
  input  logic rst,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic set,
  output logic reset,
  output logic mag_on
);

  // Bit order: {timer_done, door_closed, clearn, stopn, startn}; reset values are the idle levels.
  localparam logic [4:0] SYNC_INIT = 5'b00111;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  logic [4:0] w_async_in;
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic       r_startn_prev;

  logic w_startn_s;
  logic w_stopn_s;
  logic w_clearn_s;
  logic w_door_closed_s;
  logic w_timer_done_s;
  logic w_kill;
  logic w_start_press;

  state_t r_state;
  state_t w_state_next;
  logic   w_set_next;
  logic   r_set;
  logic   r_reset;

  assign w_async_in = {timer_done, door_closed, clearn, stopn, startn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1       <= SYNC_INIT;
      r_sync2       <= SYNC_INIT;
      r_startn_prev <= 1'b1;
    end else begin
      r_sync1       <= w_async_in;
      r_sync2       <= r_sync1;
      r_startn_prev <= r_sync2[0];
    end
  end

  assign w_startn_s      = r_sync2[0];
  assign w_stopn_s       = r_sync2[1];
  assign w_clearn_s      = r_sync2[2];
  assign w_door_closed_s = r_sync2[3];
  assign w_timer_done_s  = r_sync2[4];

  // Any interlock or stop request overrides a start press in the same cycle.
  assign w_kill        = ~w_stopn_s | ~w_clearn_s | ~w_door_closed_s | w_timer_done_s;
  assign w_start_press = r_startn_prev & ~w_startn_s;

  always_comb begin
    w_state_next = r_state;
    w_set_next   = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (w_start_press && !w_kill) begin
          w_state_next = ST_ON;
          w_set_next   = 1'b1;
        end
      end
      ST_ON: begin
        if (w_kill) begin
          w_state_next = ST_OFF;
        end
      end
      default: begin
        w_state_next = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_set   <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_set   <= w_set_next;
      r_reset <= w_kill;
    end
  end

  assign set    = r_set;
  assign reset  = r_reset;
  assign mag_on = (r_state == ST_ON);

endmodule

// File: tb/tb_controle_magnetron.sv
// Bench for controle_magnetron: directed scenarios plus random input traffic,
// checked against a sample-history model of the controller's rules.
module tb_controle_magnetron;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic startn = 1'b1;
  logic stopn = 1'b1;
  logic clearn = 1'b1;
  logic door_closed = 1'b0;
  logic timer_done = 1'b0;
  logic set;
  logic reset;
  logic mag_on;

  int errors = 0;
  int checks = 0;

  // Input samples per rising edge, oldest first; {timer, door, clear, stop, start}.
  logic [4:0] hist[$];
  logic exp_set = 1'b0;
  logic exp_reset = 1'b0;
  logic exp_mag = 1'b0;
  logic m_mag = 1'b0;

  controle_magnetron dut (
    .clk        (clk),
    .rst        (rst),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .set        (set),
    .reset      (reset),
    .mag_on     (mag_on)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    logic [4:0] idle_v;
    idle_v = 5'b00111;
    hist.delete();
    repeat (3) hist.push_back(idle_v);
    m_mag     = 1'b0;
    exp_set   = 1'b0;
    exp_reset = 1'b0;
    exp_mag   = 1'b0;
  endtask

  // Outputs after edge n reflect the inputs sampled at edge n-2 (and n-3 for the start edge).
  task automatic tick();
    logic [4:0] smp;
    logic [4:0] s_now;
    logic [4:0] s_prev;
    logic kill;
    logic sp;
    smp = {timer_done, door_closed, clearn, stopn, startn};
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hist.push_back(smp);
      s_now  = hist[hist.size()-3];
      s_prev = hist[hist.size()-4];
      kill = !s_now[1] || !s_now[2] || !s_now[3] || s_now[4];
      sp   = s_prev[0] && !s_now[0];
      exp_reset = kill;
      exp_set   = sp && !kill && !m_mag;
      if (kill) m_mag = 1'b0;
      else if (sp) m_mag = 1'b1;
      exp_mag = m_mag;
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic set_idle();
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1; timer_done = 1'b0;
  endtask

  task automatic go_on();
    set_idle();
    repeat (4) tick();
    startn = 1'b0;
    repeat (4) tick();
    startn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    door_closed = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({set, reset, mag_on} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: set/reset/mag=%b%b%b expected 000", set, reset, mag_on);
    end
    repeat (2) tick();
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({set, reset, mag_on} !== 3'b010) begin
      errors++; $display("FAIL reset_release_door_open: set/reset/mag=%b%b%b expected 010", set, reset, mag_on);
    end
  endtask

  task automatic test_start();
    set_idle();
    repeat (4) tick();
    startn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({set, reset, mag_on} !== {exp_set, exp_reset, exp_mag}) begin
        errors++; $display("FAIL start edge%0d: set/reset/mag=%b%b%b expected %b%b%b", i, set, reset, mag_on, exp_set, exp_reset, exp_mag);
      end
      if (i == 3) begin
        checks++;
        if ({set, reset, mag_on} !== 3'b101) begin
          errors++; $display("FAIL start_third_edge: set/reset/mag=%b%b%b expected 101", set, reset, mag_on);
        end
      end
      if (i == 4) begin
        checks++;
        if ({set, mag_on} !== 2'b01) begin
          errors++; $display("FAIL start_pulse_width: set/mag=%b%b expected 01", set, mag_on);
        end
      end
    end
    startn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_door_open();
    go_on();
    door_closed = 1'b0;
    repeat (3) tick();
    checks++;
    if ({set, reset, mag_on} !== 3'b010) begin
      errors++; $display("FAIL door_open: set/reset/mag=%b%b%b expected 010", set, reset, mag_on);
    end
    startn = 1'b0;
    repeat (2) tick();
    startn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (set !== 1'b0 || {reset, mag_on} !== {exp_reset, exp_mag}) begin
        errors++; $display("FAIL door_open_press cyc%0d: set/reset/mag=%b%b%b expected 0%b%b", i, set, reset, mag_on, exp_reset, exp_mag);
      end
    end
    door_closed = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_timer();
    go_on();
    timer_done = 1'b1;
    repeat (3) tick();
    checks++;
    if ({set, reset, mag_on} !== 3'b010) begin
      errors++; $display("FAIL timer_expiry: set/reset/mag=%b%b%b expected 010", set, reset, mag_on);
    end
    startn = 1'b0;
    repeat (4) tick();
    timer_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({set, mag_on} !== 2'b00 || reset !== exp_reset) begin
        errors++; $display("FAIL timer_held_start cyc%0d: set/reset/mag=%b%b%b expected 0%b0", i, set, reset, mag_on, exp_reset);
      end
    end
    startn = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_priority();
    for (int k = 0; k < 2; k++) begin
      set_idle();
      repeat (4) tick();
      startn = 1'b0;
      if (k == 0) stopn = 1'b0;
      else        clearn = 1'b0;
      repeat (3) tick();
      checks++;
      if ({set, reset, mag_on} !== 3'b010) begin
        errors++; $display("FAIL priority_%s: set/reset/mag=%b%b%b expected 010", (k == 0) ? "stop" : "clear", set, reset, mag_on);
      end
      tick();
      checks++;
      if ({set, reset, mag_on} !== {exp_set, exp_reset, exp_mag}) begin
        errors++; $display("FAIL priority_model k%0d: set/reset/mag=%b%b%b expected %b%b%b", k, set, reset, mag_on, exp_set, exp_reset, exp_mag);
      end
      set_idle();
      repeat (4) tick();
    end
  endtask

  task automatic test_reset_mid();
    go_on();
    checks++;
    if (mag_on !== 1'b1) begin
      errors++; $display("FAIL reset_mid_on: mag_on=%b expected 1", mag_on);
    end
    door_closed = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({set, reset, mag_on} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_immediate: set/reset/mag=%b%b%b expected 000", set, reset, mag_on);
    end
    tick();
    #2 rst = 1'b0;
    tick();
    checks++;
    if ({set, reset, mag_on} !== 3'b010) begin
      errors++; $display("FAIL reset_mid_release: set/reset/mag=%b%b%b expected 010", set, reset, mag_on);
    end
    set_idle();
    repeat (4) tick();
  endtask

  task automatic test_repeat_press();
    go_on();
    startn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({set, reset, mag_on} !== 3'b001) begin
        errors++; $display("FAIL repeat_press cyc%0d: set/reset/mag=%b%b%b expected 001", i, set, reset, mag_on);
      end
    end
    startn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) startn = ~startn;
      stopn       = ($urandom_range(15) != 0);
      clearn      = ($urandom_range(19) != 0);
      if ($urandom_range(9) == 0) door_closed = ~door_closed;
      timer_done  = ($urandom_range(15) == 0);
      tick();
      checks++;
      if ({set, reset, mag_on} !== {exp_set, exp_reset, exp_mag} || (set && reset)) begin
        errors++; $display("FAIL random cyc%0d: set/reset/mag=%b%b%b expected %b%b%b", i, set, reset, mag_on, exp_set, exp_reset, exp_mag);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_door_open();
    test_timer();
    test_priority();
    test_reset_mid();
    test_repeat_press();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
